machine_timer: RTL and testbench
================================

Name: machine_timer

Overview:
- Memory-mapped machine timer and software-interrupt unit.
- Sits directly upstream of the core exception/interrupt handler and drives its timer-interrupt and software-interrupt request inputs.
- Holds a 64-bit free-running mtime with a programmable prescaler, a 64-bit mtimecmp and an msip bit.
- Accessed over the core's req/gnt/rvalid data-bus handshake.

Parameters:
- PRESCALE_W, 8, width of the prescaler divide field and its counter.
- CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp. Guarantees no timer interrupt out of reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset. Synchronous, active-high.
- req_i  in  1  bus request.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- addr_i  in  32  byte address. Only addr_i[4:2] is decoded.
- data_i  in  32  write data.
- gnt_o  out  1  request granted.
- rvalid_o  out  1  response valid.
- data_o  out  32  read data.
- irq_timer_o  out  1  machine timer interrupt request.
- irq_software_o  out  1  machine software interrupt request.

Behaviour:
- Register map, by addr_i[4:2]:
  - 0 CTRL: bit0 = EN; bits[8+PRESCALE_W-1:8] = DIV.
  - 1 MTIME_LO.
  - 2 MTIME_HI.
  - 3 MTIMECMP_LO.
  - 4 MTIMECMP_HI.
  - 5 MSIP: bit0.
  - 6 and 7: unmapped. Reads return 0, writes are ignored, no error.
- Reset (rst high at a clk edge) sets:
  - CTRL = 0, mtime = 0, pre_cnt = 0, mtimecmp = CMP_RST, msip = 0, hi_shadow = 0.
  - rvalid_o = 0, data_o = 0, irq_timer_o = 0, irq_software_o = 0.
  - Reset mid-transaction drops any pending response: rvalid_o is 0 in the cycle after reset.
- Bus handshake:
  - gnt_o = req_i, combinational. Every request is accepted in the cycle it is presented.
  - rvalid_o is registered and asserts exactly 1 cycle after each accepted request, reads and writes alike.
  - Back-to-back requests give back-to-back rvalid pulses.
  - data_o is registered: the read value for reads, 0 for writes. It is held until the next response.
- Writes:
  - Applied at the clk edge of the accepted cycle.
  - Each byte lane is gated by its be_i bit.
  - Reserved CTRL and MSIP bits read as 0.
- Prescaler and tick:
  - While EN = 1, pre_cnt increments every cycle.
  - When pre_cnt == DIV, pre_cnt wraps to 0 and a tick is generated.
  - DIV = 0 therefore gives one tick per cycle; DIV = N gives one tick every N+1 cycles.
  - While EN = 0, pre_cnt and mtime hold.
  - Any write to CTRL clears pre_cnt to 0.
  - On a tick, mtime increments by 1 as full 64-bit unsigned arithmetic, with carry from LO into HI.
  - At 2^64-1, mtime wraps to 0.
- Write/tick collision:
  - A write to MTIME_LO or MTIME_HI in a tick cycle wins, and that tick is dropped entirely.
  - Neither half increments; the unwritten half holds.
  - The prescaler still advances normally.
- Coherent 64-bit read:
  - A read of MTIME_LO returns mtime[31:0] and, at the same edge, latches mtime[63:32] into hi_shadow.
  - A read of MTIME_HI returns hi_shadow, not live mtime[63:32].
  - Values are sampled at the accept edge.
- Timer interrupt:
  - irq_timer_o <= (mtime >= mtimecmp), 64-bit unsigned compare of the current register values.
  - Latency is 1 cycle after the condition becomes true or false.
  - The compare is independent of EN.
  - Writing mtimecmp above mtime deasserts irq_timer_o 1 cycle after the write edge.
- Software interrupt:
  - irq_software_o <= msip, 1 cycle after msip changes.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, irq_timer_o stays 0 (mtime=0, mtimecmp=all ones); read MTIMECMP_LO -> rvalid_o 1 cycle later, data_o=32'hFFFF_FFFF.
- Write CTRL=0x0000_0301 (EN=1, DIV=3), run 40 cycles, read MTIME_LO -> data_o=10; ticks are exactly 4 cycles apart.
- Write MTIME_LO=32'hFFFF_FFFE and MTIME_HI=0 with DIV=0, EN=1, wait 3 cycles, read MTIME_LO then MTIME_HI -> HI returns 1 (carry into HI), and HI equals the snapshot taken at the LO read even if mtime advances between the two reads.
- Set mtimecmp=100, mtime=95, DIV=0, EN=1 -> irq_timer_o rises exactly 1 cycle after mtime reaches 100; write MTIMECMP_LO=200 -> irq_timer_o falls 1 cycle after the write edge.
- Write MTIME_LO=0x50 in a cycle that would tick -> the following read returns 0x50 (tick dropped); with DIV=0, the next cycle resumes at 0x51.
- Write MSIP with be_i=4'b0001 and data 1 -> irq_software_o=1 one cycle later; write with be_i=0 -> no change; write to addr 0x18 -> rvalid_o pulse, data_o=0, no register state changes.

Source files
------------

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped 64-bit machine timer with prescaler, compare interrupt and software interrupt
module machine_timer #(
    parameter int          PRESCALE_W = 8,
    parameter logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] data_o,
    output logic        irq_timer_o,
    output logic        irq_software_o
);
    logic                  r_en;
    logic [PRESCALE_W-1:0] r_div;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic                  r_msip;
    logic [31:0]           r_hi_shadow;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic                  r_irq_timer;
    logic                  r_irq_sw;
    logic [2:0]            w_sel;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_tick;
    logic [31:0]           w_ctrl;
    logic [31:0]           w_ctrl_wr;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return m;
    endfunction

    assign w_sel     = addr_i[4:2];
    assign w_wr      = req_i & we_i;
    assign w_rd      = req_i & ~we_i;
    assign w_tick    = r_en && (r_pre_cnt == r_div);
    assign w_ctrl    = {{(24-PRESCALE_W){1'b0}}, r_div, 7'd0, r_en};
    assign w_ctrl_wr = f_merge(w_ctrl, data_i, be_i);
    assign w_unused  = ^{addr_i[31:5], addr_i[1:0], w_ctrl_wr[31:8+PRESCALE_W], w_ctrl_wr[7:0]};

    assign gnt_o          = req_i;
    assign rvalid_o       = r_rvalid;
    assign data_o         = r_rdata;
    assign irq_timer_o    = r_irq_timer;
    assign irq_software_o = r_irq_sw;

    // read mux over the register map; unmapped slots read as zero
    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            3'd0:    w_rdata = w_ctrl;
            3'd1:    w_rdata = r_mtime[31:0];
            3'd2:    w_rdata = r_hi_shadow;
            3'd3:    w_rdata = r_mtimecmp[31:0];
            3'd4:    w_rdata = r_mtimecmp[63:32];
            3'd5:    w_rdata = {31'd0, r_msip};
            default: w_rdata = 32'd0;
        endcase
    end

    // one-cycle response for every accepted request; writes answer with zero data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= req_i;
            if (req_i) r_rdata <= we_i ? 32'd0 : w_rdata;
        end
    end

    // control register and prescaler; any CTRL write restarts the divide count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_div     <= '0;
            r_pre_cnt <= '0;
        end else begin
            if (w_wr && w_sel == 3'd0) begin
                r_en      <= w_ctrl_wr[0];
                r_div     <= w_ctrl_wr[8 +: PRESCALE_W];
                r_pre_cnt <= '0;
            end else if (r_en) begin
                r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRESCALE_W'(1);
            end
        end
    end

    // mtime: a bus write to either half wins over a coincident tick, which is dropped
    always_ff @(posedge clk) begin
        if (rst) r_mtime <= 64'd0;
        else if (w_wr && w_sel == 3'd1) r_mtime[31:0] <= f_merge(r_mtime[31:0], data_i, be_i);
        else if (w_wr && w_sel == 3'd2) r_mtime[63:32] <= f_merge(r_mtime[63:32], data_i, be_i);
        else if (w_tick) r_mtime <= r_mtime + 64'd1;
    end

    // reading the low half snapshots the high half so a LO-then-HI pair is coherent
    always_ff @(posedge clk) begin
        if (rst) r_hi_shadow <= 32'd0;
        else if (w_rd && w_sel == 3'd1) r_hi_shadow <= r_mtime[63:32];
    end

    // compare value and software-interrupt bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtimecmp <= CMP_RST;
            r_msip     <= 1'b0;
        end else begin
            if (w_wr && w_sel == 3'd3) r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], data_i, be_i);
            if (w_wr && w_sel == 3'd4) r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], data_i, be_i);
            if (w_wr && w_sel == 3'd5 && be_i[0]) r_msip <= data_i[0];
        end
    end

    // registered interrupt requests, one cycle behind the register state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_timer <= 1'b0;
            r_irq_sw    <= 1'b0;
        end else begin
            r_irq_timer <= r_mtime >= r_mtimecmp;
            r_irq_sw    <= r_msip;
        end
    end
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: vector table plus timing sequences, responses checked through a scoreboard queue
module tb_machine_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] data_o;
    logic        irq_timer_o;
    logic        irq_software_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic        req_seen = 1'b0;
    logic        mon_en = 1'b0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    machine_timer dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .data_i(data_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .data_o(data_o), .irq_timer_o(irq_timer_o), .irq_software_o(irq_software_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) req_seen <= req_i && !rst;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rvalid_timing", rvalid_o, req_seen);
            if (rvalid_o) begin
                chk("sb_pending", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) chk("rdata", data_o, sb_q.pop_front());
            end
        end
    end

    task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp);
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; data_i = data;
        sb_q.push_back(we ? 32'd0 : exp);
        #1 chk("gnt", gnt_o, 1);
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, 4'hF, addr, data, 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        bus(1'b0, 4'h0, addr, 32'd0, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        vecs.push_back('{1'b0, 4'h0, 32'h0C, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 4'h0, 32'h10, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 4'hF, 32'h0C, 32'h1234_5678, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h0C, 32'h0, 32'h1234_5678});
        vecs.push_back('{1'b1, 4'h5, 32'h0C, 32'hAABB_CCDD, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h0C, 32'h0, 32'h12BB_56DD});
        vecs.push_back('{1'b1, 4'hF, 32'h00, 32'hFFFF_FF00, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h00, 32'h0, 32'h0000_FF00});
        vecs.push_back('{1'b1, 4'hF, 32'h14, 32'hFFFF_FFFE, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h14, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 4'hF, 32'h08, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h04, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h08, 32'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 4'hF, 32'h08, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h08, 32'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 4'h0, 32'h04, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h08, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 4'hF, 32'h18, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b1, 4'hF, 32'h1C, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h18, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h1C, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h00, 32'h0, 32'h0000_FF00});
        vecs.push_back('{1'b0, 4'h0, 32'h0C, 32'h0, 32'h12BB_56DD});
        vecs.push_back('{1'b0, 4'h0, 32'h14, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 4'hF, 32'h0C, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b1, 4'hF, 32'h00, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 4'h0, 32'h00, 32'h0, 32'h0});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_data", data_o, 0);
        chk("rst_irq_timer", irq_timer_o, 0);
        chk("rst_irq_sw", irq_software_o, 0);
        chk("idle_gnt", gnt_o, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_irq_timer", irq_timer_o, 0);
        end
        @(posedge clk); #1;

        foreach (vecs[i]) bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        wr(32'h00, 32'h0000_0301);
        idle(40);
        for (int i = 0; i < 8; i++) rd(32'h04, 32'((40 + i) / 4));
        wr(32'h00, 32'h0);

        wr(32'h04, 32'hFFFF_FFFE);
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h1);
        idle(3);
        rd(32'h04, 32'h1);
        rd(32'h08, 32'h1);
        wr(32'h08, 32'h5);
        rd(32'h08, 32'h1);
        rd(32'h04, 32'h4);
        rd(32'h08, 32'h5);

        wr(32'h04, 32'h50);
        rd(32'h04, 32'h50);
        rd(32'h04, 32'h51);
        rd(32'h08, 32'h5);

        wr(32'h00, 32'h0000_0301);
        idle(3);
        wr(32'h04, 32'h70);
        for (int i = 0; i < 4; i++) rd(32'h04, 32'h70);
        rd(32'h04, 32'h71);
        wr(32'h00, 32'h0);

        wr(32'h08, 32'h0);
        wr(32'h04, 32'd95);
        wr(32'h10, 32'h0);
        wr(32'h0C, 32'd100);
        wr(32'h00, 32'h1);
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("irq_timer_rise", irq_timer_o, j == 6);
        end
        @(posedge clk); #1;
        wr(32'h0C, 32'd200);
        @(negedge clk);
        chk("irq_timer_hold", irq_timer_o, 1);
        @(posedge clk);
        @(negedge clk);
        chk("irq_timer_fall", irq_timer_o, 0);
        @(posedge clk); #1;
        wr(32'h00, 32'h0);

        bus(1'b1, 4'b0001, 32'h14, 32'h1, 32'h0);
        @(negedge clk);
        chk("msip_lat0", irq_software_o, 0);
        @(posedge clk);
        @(negedge clk);
        chk("msip_set", irq_software_o, 1);
        @(posedge clk); #1;
        bus(1'b1, 4'b0000, 32'h14, 32'h0, 32'h0);
        @(negedge clk);
        chk("msip_be0", irq_software_o, 1);
        @(posedge clk); #1;
        rd(32'h14, 32'h1);
        bus(1'b1, 4'b0001, 32'h14, 32'h0, 32'h0);
        @(negedge clk);
        chk("msip_clr_lat", irq_software_o, 1);
        @(posedge clk);
        @(negedge clk);
        chk("msip_clr", irq_software_o, 0);
        @(posedge clk); #1;
        wr(32'h18, 32'hFFFF_FFFF);
        rd(32'h0C, 32'd200);

        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0C; rst = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("midrst_data", data_o, 0);
        chk("midrst_irq_timer", irq_timer_o, 0);
        @(posedge clk); #1;
        rd(32'h0C, 32'hFFFF_FFFF);
        rd(32'h04, 32'h0);
        rd(32'h00, 32'h0);
        idle(2);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
